d_latch_driver: RTL and testbench

//  Upstream stage for the level-sensitive D latch. Takes a raw asynchronous data input and does three things:

---
 rtl/d_latch_driver.sv | 122 ++++++++++++
 tb/tb_d_latch_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/d_latch_driver.sv
// Front end for a level-sensitive D latch: synchronizes and debounces a raw input,
// then presents it to the latch as a setup / enable-strobe / hold sequence.
module d_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STROBE_LEN      = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Din,
    input  logic       Load,
    output logic       D,
    output logic       E,
    output logic       Busy,
    output logic [2:0] Dbg_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STROBE_LEN + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync_q;
    logic          stable_q, stable_d;
    logic          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          d_q, d_d;
    logic          e_q, busy_q;

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        scnt_d   = scnt_q;
        d_d      = d_q;
        unique case (state_q)
            IDLE: begin
                // A pending change outranks a Load request in the same cycle.
                if (sync_q != stable_q) begin
                    state_d = CHECK;
                    cand_d  = sync_q;
                    cnt_d   = CW'(1);
                end else if (Load) begin
                    state_d = SETUP;
                    d_d     = stable_q;
                end
            end
            CHECK: begin
                if (sync_q != cand_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d  = SETUP;
                    stable_d = cand_q;
                    d_d      = cand_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SETUP: begin
                state_d = STROBE;
                scnt_d  = SW'(1);
            end
            STROBE: begin
                if (scnt_q == SW'(STROBE_LEN)) begin
                    state_d = HOLD;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // E and Busy are registered from the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            state_q  <= IDLE;
            stable_q <= 1'b0;
            cand_q   <= 1'b0;
            cnt_q    <= '0;
            scnt_q   <= '0;
            d_q      <= 1'b0;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= Din;
            sync_q   <= sync1_q;
            state_q  <= state_d;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            d_q      <= d_d;
            e_q      <= (state_d == STROBE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign D         = d_q;
    assign E         = e_q;
    assign Busy      = busy_q;
    assign Dbg_state = state_q;

endmodule

// File: tb/tb_d_latch_driver.sv
// Directed bench for d_latch_driver: power-up, debounce latency, glitch rejection,
// Load re-strobe, change during strobe and asynchronous abort.
module tb_d_latch_driver;

    logic       Clk;
    logic       Rst_n;
    logic       Din;
    logic       Load;
    logic       D;
    logic       E;
    logic       Busy;
    logic [2:0] Dbg_state;

    int checks;
    int failures;
    int hold_viol;
    logic mon_pd, mon_pe;

    d_latch_driver #(.DEBOUNCE_CYCLES(4), .STROBE_LEN(2)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Din      (Din),
        .Load     (Load),
        .D        (D),
        .E        (E),
        .Busy     (Busy),
        .Dbg_state(Dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // D must not move in the cycle E rises, while E is high, or the cycle after E falls.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            mon_pd <= 1'b0;
            mon_pe <= 1'b0;
        end else begin
            if ((E || mon_pe) && (D != mon_pd)) hold_viol <= hold_viol + 1;
            mon_pd <= D;
            mon_pe <= E;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_e(input string tag);
        int n;
        n = 0;
        while (!E && n < 30) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, E}, 32'd1);
    endtask

    initial begin
        int e_seen, rises, len;
        logic d_at, pe;
        checks = 0; failures = 0; hold_viol = 0;
        Rst_n = 1'b0; Din = 1'b1; Load = 1'b0;

        // 1. power-up with Din=1
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_d", {31'd0, D}, 32'd0);
            chk("rst_e", {31'd0, E}, 32'd0);
            chk("rst_busy", {31'd0, Busy}, 32'd0);
        end
        chk("rst_state", {29'd0, Dbg_state}, 32'd0);
        Rst_n = 1'b1;
        wait_e("pwr_e_rise");
        chk("pwr_d", {31'd0, D}, 32'd1);
        tick();
        chk("pwr_e_2nd", {31'd0, E}, 32'd1);
        tick();
        chk("pwr_e_fall", {31'd0, E}, 32'd0);
        tick();
        chk("pwr_busy_end", {31'd0, Busy}, 32'd0);
        repeat (3) tick();

        // 4. Load re-strobe with S=1; Load pulsed again while busy
        Load = 1'b1;
        tick();
        Load = 1'b0;
        chk("ld_setup_busy", {31'd0, Busy}, 32'd1);
        chk("ld_setup_e", {31'd0, E}, 32'd0);
        tick();
        chk("ld_e_j2", {31'd0, E}, 32'd1);
        chk("ld_d_j2", {31'd0, D}, 32'd1);
        tick();
        chk("ld_e_j3", {31'd0, E}, 32'd1);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        chk("ld_e_j4", {31'd0, E}, 32'd0);
        chk("ld_busy_j4", {31'd0, Busy}, 32'd1);
        tick();
        chk("ld_busy_j5", {31'd0, Busy}, 32'd0);
        e_seen = 0;
        repeat (8) begin
            tick();
            if (E) e_seen++;
        end
        chk("ld_busy_ignored", e_seen, 0);
        chk("ld_d_hold", {31'd0, D}, 32'd1);

        // return to S=0
        Din = 1'b0;
        repeat (20) tick();
        chk("to0_d", {31'd0, D}, 32'd0);
        chk("to0_busy", {31'd0, Busy}, 32'd0);

        // 2. exact latency for 0->1, k is the first sampling edge
        Din = 1'b1;
        tick();
        repeat (4) tick();
        chk("lat_d_k4", {31'd0, D}, 32'd0);
        tick();
        chk("lat_d_k5", {31'd0, D}, 32'd1);
        chk("lat_e_k5", {31'd0, E}, 32'd0);
        chk("lat_busy_k5", {31'd0, Busy}, 32'd1);
        tick();
        chk("lat_e_k6", {31'd0, E}, 32'd1);
        tick();
        chk("lat_e_k7", {31'd0, E}, 32'd1);
        tick();
        chk("lat_e_k8", {31'd0, E}, 32'd0);
        chk("lat_busy_k8", {31'd0, Busy}, 32'd1);
        tick();
        chk("lat_busy_k9", {31'd0, Busy}, 32'd0);

        Din = 1'b0;
        repeat (20) tick();
        chk("to0b_d", {31'd0, D}, 32'd0);

        // 3. three-sample glitch is rejected
        Din = 1'b1;
        repeat (3) tick();
        Din = 1'b0;
        e_seen = 0;
        repeat (12) begin
            tick();
            if (E) e_seen++;
        end
        chk("glitch_e", e_seen, 0);
        chk("glitch_d", {31'd0, D}, 32'd0);
        chk("glitch_busy", {31'd0, Busy}, 32'd0);

        // 5. Din drops back to 0 during the strobe
        Din = 1'b1;
        wait_e("tog_e_rise");
        Din = 1'b0;
        chk("tog_d_first", {31'd0, D}, 32'd1);
        rises = 0; len = 0; d_at = 1'b1; pe = 1'b1;
        repeat (30) begin
            tick();
            if (E && !pe) begin
                rises++;
                d_at = D;
            end
            if (E && rises == 1) len++;
            pe = E;
        end
        chk("tog_rises", rises, 1);
        chk("tog_d_second", {31'd0, d_at}, 32'd0);
        chk("tog_len", len, 2);
        chk("tog_busy", {31'd0, Busy}, 32'd0);

        // 6. asynchronous abort while E is high
        Din = 1'b1;
        wait_e("abort_e_rise");
        #2;
        Rst_n = 1'b0;
        Din = 1'b0;
        #1;
        chk("abort_e", {31'd0, E}, 32'd0);
        chk("abort_d", {31'd0, D}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        tick();
        tick();
        Rst_n = 1'b1;
        e_seen = 0;
        repeat (15) begin
            tick();
            if (E) e_seen++;
        end
        chk("abort_no_e", e_seen, 0);
        chk("abort_d_after", {31'd0, D}, 32'd0);

        chk("d_stable_around_e", hold_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
